// File: rtl/fc_sched_pkg.sv
// Shared types and helpers for the fully-connected MAC scheduler.
package fc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    // Bit positions inside the tag that travels with each issued read.
    localparam int unsigned TAG_FIRST    = 0;
    localparam int unsigned TAG_LAST     = 1;
    localparam int unsigned TAG_NODE_LSB = 2;

    function automatic int unsigned chunks(input int unsigned n_in, input int unsigned lanes);
        return (n_in + lanes - 1) / lanes;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_sched_delay.sv
// Valid+payload shift register with synchronous active-low clear; DEPTH=0 is a wire.
module fc_sched_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         empty
);

    generate
        if (DEPTH == 0) begin : g_pass
            always_comb begin
                out_valid = in_valid;
                out_data  = in_data;
                empty     = !in_valid;
            end
        end else begin : g_pipe
            logic [DEPTH-1:0] vld;
            logic [W-1:0]     dat [DEPTH];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    vld <= '0;
                    for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
                end else begin
                    vld[0] <= in_valid;
                    dat[0] <= in_valid ? in_data : '0;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        vld[i] <= vld[i-1];
                        dat[i] <= dat[i-1];
                    end
                end
            end

            always_comb begin
                out_valid = vld[DEPTH-1];
                out_data  = dat[DEPTH-1];
                empty     = ~|vld;
            end
        end
    endgenerate

endmodule

// File: rtl/fc_mac_scheduler.sv
// Walks every (output node, input chunk) pair, issuing feature/weight reads and
// MAC strobes aligned to the returning data; pulses done after the last capture.
module fc_mac_scheduler
    import fc_sched_pkg::*;
#(
    parameter int unsigned input_nodes    = 784,
    parameter int unsigned output_nodes   = 2,
    parameter int unsigned Mult_Add_Units = 16,
    parameter int unsigned ROM_LAT        = 1,
    parameter int unsigned MAC_LAT        = 2,
    parameter int unsigned WADDR_W        = 7,
    localparam int unsigned CHUNKS = chunks(input_nodes, Mult_Add_Units),
    localparam int unsigned CW     = idx_width(CHUNKS),
    localparam int unsigned NW     = idx_width(output_nodes)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               feat_ready,
    output logic [CW-1:0]      feat_addr,
    output logic               feat_rd,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               rom_en,
    output logic               mac_valid,
    output logic               mac_clear,
    output logic               mac_last,
    output logic               acc_capture,
    output logic [NW-1:0]      node_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned TW = NW + 2;

    sched_state_t       state;
    logic               start_q;
    logic [CW-1:0]      c;
    logic [NW-1:0]      n;
    logic [WADDR_W-1:0] waddr;

    logic               c_first, c_last, n_last, issue_fire;
    logic [TW-1:0]      iss_in_data, iss_out_data;
    logic               iss_out_valid, iss_empty;
    logic               cap_in_valid, cap_out_valid, cap_empty;
    logic [NW-1:0]      cap_in_data, cap_out_data;

    always_comb begin
        c_first     = (c == '0);
        c_last      = (c == CW'(CHUNKS - 1));
        n_last      = (n == NW'(output_nodes - 1));
        issue_fire  = (state == ISSUE) && feat_ready;
        iss_in_data = {n, c_last, c_first};
        // The capture line is fed from the same beat that becomes mac_last on the
        // next edge, so MAC_LAT=0 makes acc_capture coincide with mac_last.
        cap_in_valid = iss_out_valid && iss_out_data[TAG_LAST];
        cap_in_data  = iss_out_data[TAG_NODE_LSB +: NW];
    end

    fc_sched_delay #(
        .DEPTH (ROM_LAT),
        .W     (TW)
    ) u_issue_dly (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_fire),
        .in_data   (iss_in_data),
        .out_valid (iss_out_valid),
        .out_data  (iss_out_data),
        .empty     (iss_empty)
    );

    fc_sched_delay #(
        .DEPTH (MAC_LAT),
        .W     (NW)
    ) u_capture_dly (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (cap_in_valid),
        .in_data   (cap_in_data),
        .out_valid (cap_out_valid),
        .out_data  (cap_out_data),
        .empty     (cap_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            c           <= '0;
            n           <= '0;
            waddr       <= '0;
            feat_addr   <= '0;
            feat_rd     <= 1'b0;
            weight_addr <= '0;
            rom_en      <= 1'b0;
            mac_valid   <= 1'b0;
            mac_clear   <= 1'b0;
            mac_last    <= 1'b0;
            acc_capture <= 1'b0;
            node_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_q     <= start;
            feat_rd     <= 1'b0;
            rom_en      <= 1'b0;
            done        <= 1'b0;
            mac_valid   <= iss_out_valid;
            mac_clear   <= iss_out_valid && iss_out_data[TAG_FIRST];
            mac_last    <= cap_in_valid;
            acc_capture <= cap_out_valid;
            node_idx    <= cap_out_valid ? cap_out_data : '0;

            unique case (state)
                IDLE: begin
                    if (start && !start_q) begin
                        state <= ISSUE;
                        c     <= '0;
                        n     <= '0;
                        waddr <= '0;
                    end
                end
                ISSUE: begin
                    busy <= 1'b1;
                    if (feat_ready) begin
                        feat_rd     <= 1'b1;
                        rom_en      <= 1'b1;
                        feat_addr   <= c;
                        weight_addr <= waddr;
                        waddr       <= waddr + WADDR_W'(1);
                        if (c_last) begin
                            c <= '0;
                            if (n_last) state <= DRAIN;
                            else        n     <= n + NW'(1);
                        end else begin
                            c <= c + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (iss_empty && cap_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_mac_scheduler.sv
// Scoreboard bench: stimulus queues expected reads/beats/captures, a negedge
// monitor pops and compares them as the scheduler presents each strobe.
module tb_fc_mac_scheduler;

    localparam int CH    = 49;
    localparam int NODES = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, start = 1'b0, start_b = 1'b0, feat_ready = 1'b1;

    logic [5:0] feat_addr;
    logic [6:0] weight_addr;
    logic [0:0] node_idx;
    logic feat_rd, rom_en, mac_valid, mac_clear, mac_last, acc_capture, busy, done;

    logic [0:0] feat_addr_b;
    logic [1:0] weight_addr_b;
    logic [1:0] node_idx_b;
    logic feat_rd_b, rom_en_b, mac_valid_b, mac_clear_b, mac_last_b, acc_capture_b, busy_b, done_b;

    fc_mac_scheduler #(
        .input_nodes(784), .output_nodes(2), .Mult_Add_Units(16),
        .ROM_LAT(1), .MAC_LAT(2), .WADDR_W(7)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .feat_ready(feat_ready),
        .feat_addr(feat_addr), .feat_rd(feat_rd), .weight_addr(weight_addr),
        .rom_en(rom_en), .mac_valid(mac_valid), .mac_clear(mac_clear),
        .mac_last(mac_last), .acc_capture(acc_capture), .node_idx(node_idx),
        .busy(busy), .done(done)
    );

    fc_mac_scheduler #(
        .input_nodes(16), .output_nodes(3), .Mult_Add_Units(16),
        .ROM_LAT(2), .MAC_LAT(0), .WADDR_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .feat_ready(1'b1),
        .feat_addr(feat_addr_b), .feat_rd(feat_rd_b), .weight_addr(weight_addr_b),
        .rom_en(rom_en_b), .mac_valid(mac_valid_b), .mac_clear(mac_clear_b),
        .mac_last(mac_last_b), .acc_capture(acc_capture_b), .node_idx(node_idx_b),
        .busy(busy_b), .done(done_b)
    );

    int tests = 0, fails = 0, cyc = 0, done_cnt = 0, done_cnt_b = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct { int t; int fa; int wa; } addr_e;
    typedef struct { int t; logic clr; logic lst; } beat_e;
    typedef struct { int t; int node; } cap_e;
    typedef struct { int t; logic val; } pt_e;

    addr_e aq[$];
    beat_e bq[$];
    cap_e  cq[$];
    int    dq[$];
    pt_e   pq[$];

    // Expected traffic for one default-config run launched at edge 'launch'.
    // With every feat_ready high: read k at launch+1+k, beat k at launch+2+k,
    // capture n at launch+52+49n, done at launch+102, busy launch+1..launch+101.
    task automatic plan_run(input int launch, input bit timed);
        int k = 0;
        for (int nd = 0; nd < NODES; nd++) begin
            for (int ck = 0; ck < CH; ck++) begin
                aq.push_back('{timed ? launch + 1 + k : -1, ck, k});
                bq.push_back('{timed ? launch + 2 + k : -1, (ck == 0), (ck == CH - 1)});
                k++;
            end
            cq.push_back('{timed ? launch + 52 + 49 * nd : -1, nd});
        end
        dq.push_back(timed ? launch + 102 : -1);
        if (timed) begin
            pq.push_back('{launch, 1'b0});
            pq.push_back('{launch + 1, 1'b1});
            pq.push_back('{launch + 101, 1'b1});
            pq.push_back('{launch + 102, 1'b0});
        end
    endtask

    always @(negedge clk) begin
        addr_e ea;
        beat_e eb;
        cap_e  ec;
        int    ed;
        if (rom_en) begin
            chk("feat_rd with rom_en", feat_rd, 1'b1);
            if (aq.size() == 0) chk("unexpected rom_en", rom_en, 1'b0);
            else begin
                ea = aq.pop_front();
                chk("feat_addr", feat_addr, ea.fa);
                chk("weight_addr", weight_addr, ea.wa);
                if (ea.t >= 0) chk("rom_en cycle", cyc, ea.t);
            end
        end else chk("feat_rd idle", feat_rd, 1'b0);

        if (mac_valid) begin
            if (bq.size() == 0) chk("unexpected mac_valid", mac_valid, 1'b0);
            else begin
                eb = bq.pop_front();
                chk("mac_clear", mac_clear, eb.clr);
                chk("mac_last", mac_last, eb.lst);
                if (eb.t >= 0) chk("mac_valid cycle", cyc, eb.t);
            end
        end else begin
            chk("mac_clear idle", mac_clear, 1'b0);
            chk("mac_last idle", mac_last, 1'b0);
        end

        if (acc_capture) begin
            if (cq.size() == 0) chk("unexpected acc_capture", acc_capture, 1'b0);
            else begin
                ec = cq.pop_front();
                chk("node_idx", node_idx, ec.node);
                if (ec.t >= 0) chk("acc_capture cycle", cyc, ec.t);
            end
        end else chk("node_idx idle", node_idx, 1'b0);

        if (pq.size() > 0 && pq[0].t == cyc) begin
            chk("busy window", busy, pq[0].val);
            void'(pq.pop_front());
        end

        if (done) begin
            done_cnt++;
            chk("busy at done", busy, 1'b0);
            if (dq.size() == 0) chk("unexpected done", done, 1'b0);
            else begin
                ed = dq.pop_front();
                if (ed >= 0) chk("done cycle", cyc, ed);
                chk("reads left at done", aq.size(), 0);
                chk("beats left at done", bq.size(), 0);
                chk("captures left at done", cq.size(), 0);
            end
        end
    end

    // Second instance: CHUNKS=1, ROM_LAT=2, MAC_LAT=0, three nodes.
    int launch_b = 0, rb_next = 0, nb_next = 0, done_t_b = 0;
    int bq_b[$];

    always @(negedge clk) begin
        if (rom_en_b) begin
            chk("B weight_addr", weight_addr_b, rb_next);
            chk("B feat_addr", feat_addr_b, 1'b0);
            chk("B rom_en cycle", cyc, launch_b + 1 + rb_next);
            rb_next++;
        end
        if (mac_valid_b) begin
            if (bq_b.size() == 0) chk("B unexpected beat", mac_valid_b, 1'b0);
            else begin
                chk("B beat cycle", cyc, bq_b[0]);
                void'(bq_b.pop_front());
                chk("B mac_clear", mac_clear_b, 1'b1);
                chk("B mac_last", mac_last_b, 1'b1);
                chk("B capture with last", acc_capture_b, 1'b1);
                chk("B node_idx", node_idx_b, nb_next);
                nb_next++;
            end
        end else chk("B capture without beat", acc_capture_b, 1'b0);
        if (done_b) begin
            done_cnt_b++;
            chk("B done cycle", cyc, done_t_b);
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        chk("done reached", done_cnt, target);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " rom_en"}, rom_en, 1'b0);
        chk({tag, " feat_rd"}, feat_rd, 1'b0);
        chk({tag, " weight_addr"}, weight_addr, 7'd0);
        chk({tag, " feat_addr"}, feat_addr, 6'd0);
        chk({tag, " mac_valid"}, mac_valid, 1'b0);
        chk({tag, " mac_clear"}, mac_clear, 1'b0);
        chk({tag, " mac_last"}, mac_last, 1'b0);
        chk({tag, " acc_capture"}, acc_capture, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
    endtask

    initial begin
        int l;
        int k;
        repeat (3) @(posedge clk);
        #2;
        chk_outputs_zero("reset");
        reset = 1'b1;
        @(posedge clk); #2;

        // Full-rate run with exact timing.
        l = cyc + 1;
        plan_run(l, 1'b1);
        start = 1'b1;
        wait_done(1, 300);

        // Start held high after done must not relaunch.
        repeat (30) @(posedge clk);
        #2;
        chk("no relaunch", done_cnt, 1);
        chk("idle busy", busy, 1'b0);

        // Drop then raise: a new run from weight_addr 0.
        start = 1'b0;
        @(posedge clk); #2;
        l = cyc + 1;
        plan_run(l, 1'b1);
        start = 1'b1;
        wait_done(2, 300);
        start = 1'b0;
        @(posedge clk); #2;

        // Random stalls with repeated start edges during ISSUE and DRAIN.
        plan_run(0, 1'b0);
        start = 1'b1;
        k = 0;
        while (done_cnt < 3 && k < 1000) begin
            feat_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
            k++;
            if (k % 2 == 0) start = ~start;
        end
        chk("stalled run done", done_cnt, 3);
        feat_ready = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("single done after stalls", done_cnt, 3);
        start = 1'b0;
        @(posedge clk); #2;

        // Reset mid-run with start held high, then a fresh run.
        l = cyc + 1;
        plan_run(l, 1'b1);
        start = 1'b1;
        while (cyc < l + 39) begin
            @(posedge clk); #2;
        end
        reset = 1'b0;
        @(posedge clk); #2;
        chk_outputs_zero("mid-run reset");
        aq.delete(); bq.delete(); cq.delete(); dq.delete(); pq.delete();
        @(posedge clk); #2;
        reset = 1'b1;
        l = cyc + 1;
        plan_run(l, 1'b1);
        wait_done(4, 300);
        start = 1'b0;
        @(posedge clk); #2;

        // Single-chunk configuration.
        l = cyc + 1;
        launch_b = l;
        bq_b.push_back(l + 3);
        bq_b.push_back(l + 4);
        bq_b.push_back(l + 5);
        done_t_b = l + 6;
        start_b = 1'b1;
        k = 0;
        while (done_cnt_b < 1 && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        chk("B done reached", done_cnt_b, 1);
        repeat (5) @(posedge clk);
        #2;
        chk("B beats consumed", bq_b.size(), 0);
        chk("B capture count", nb_next, 3);
        chk("B read count", rb_next, 3);
        chk("B single done", done_cnt_b, 1);
        start_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
